// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state encoding, owner
// codes and exception codes.
package mem_arb_pkg;

    localparam int ADDR_W = 36;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int CODE_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_F = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_F    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    localparam logic [CODE_W-1:0] CODE_OK          = 16'h0000;
    localparam logic [CODE_W-1:0] TIMEOUT_CODE_DEF = 16'h0005;

    // Increment that stops at lim.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory port arbiter. The module only exists
// when ARB_TIMEOUT_EN is defined; without it the arbiter has no watchdog.
// Down-counter: clear loads LIMIT-1, each enabled cycle counts down, and
// expired flags the LIMIT-th enabled cycle after a clear.
`ifdef ARB_TIMEOUT_EN
module mem_arb_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: reload on clear, count down while enabled, park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == '0);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares the single 64-bit memory port between instruction fetch (F) and
// load/store (D). D wins ties unless F has lost STARVE_LIMIT arbitrations in
// a row. Optional busy watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | sample f_req/d_req, register winner onto m_*
// BUSY_F    | fetch transaction outstanding, m_* held until m_ack
// BUSY_D    | load/store transaction outstanding, m_* held until m_ack
// RESP      | ack pulse visible to requester; bubble so a stale held
//           | request is not re-granted
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] TIMEOUT_CODE   = TIMEOUT_CODE_DEF
) (
    input  logic              clock,
    input  logic              reset_in,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    output logic [CODE_W-1:0] f_code,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [CODE_W-1:0] d_code,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [BE_W-1:0]   m_be,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [CODE_W-1:0] m_code,
    output logic [1:0]        owner
);
    localparam logic [3:0] LOSS_LIM = 4'(STARVE_LIMIT);

    logic [1:0]        state_q,   state_d;
    logic [3:0]        loss_q,    loss_d;
    logic              m_req_q,   m_req_d;
    logic              m_we_q,    m_we_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [BE_W-1:0]   m_be_q,    m_be_d;
    logic              f_ack_q,   f_ack_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [CODE_W-1:0] f_code_q,  f_code_d;
    logic              d_ack_q,   d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [CODE_W-1:0] d_code_q,  d_code_d;
    logic [1:0]        owner_q,   owner_d;

`ifdef ARB_TIMEOUT_EN
    logic wd_clear, wd_enable, wd_expired;

    assign wd_clear  = (state_q == ST_IDLE) && (f_req || d_req);
    assign wd_enable = (state_q == ST_BUSY_F) || (state_q == ST_BUSY_D);

    mem_arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset_in (reset_in),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .expired  (wd_expired)
    );
`endif

    // Arbitration, transaction tracking and response capture.
    always_comb begin
        state_d   = state_q;
        loss_d    = loss_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        f_ack_d   = 1'b0;
        f_rdata_d = f_rdata_q;
        f_code_d  = f_code_q;
        d_ack_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        d_code_d  = d_code_q;
        owner_d   = owner_q;

        case (state_q)
            ST_IDLE: begin
                if (f_req && (!d_req || (loss_q == LOSS_LIM))) begin
                    // Fetch carries no write data; it always reads the full word.
                    state_d   = ST_BUSY_F;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = f_addr;
                    m_wdata_d = '0;
                    m_be_d    = '1;
                    owner_d   = OWN_F;
                    loss_d    = '0;
                end else if (d_req) begin
                    state_d   = ST_BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_be_d    = d_be;
                    owner_d   = OWN_D;
                    if (f_req) begin
                        loss_d = sat_inc(loss_q, LOSS_LIM);
                    end
                end
            end
            ST_BUSY_F, ST_BUSY_D: begin
                if (m_ack) begin
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    if (state_q == ST_BUSY_F) begin
                        f_ack_d   = 1'b1;
                        f_rdata_d = m_rdata;
                        f_code_d  = m_code;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_rdata;
                        d_code_d  = m_code;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    if (state_q == ST_BUSY_F) begin
                        f_ack_d   = 1'b1;
                        f_rdata_d = '0;
                        f_code_d  = TIMEOUT_CODE;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                        d_code_d  = TIMEOUT_CODE;
                    end
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any outstanding transaction.
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            loss_q    <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            f_ack_q   <= 1'b0;
            f_rdata_q <= '0;
            f_code_q  <= CODE_OK;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            d_code_q  <= CODE_OK;
            owner_q   <= OWN_NONE;
        end else begin
            state_q   <= state_d;
            loss_q    <= loss_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            f_ack_q   <= f_ack_d;
            f_rdata_q <= f_rdata_d;
            f_code_q  <= f_code_d;
            d_ack_q   <= d_ack_d;
            d_rdata_q <= d_rdata_d;
            d_code_q  <= d_code_d;
            owner_q   <= owner_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign f_ack   = f_ack_q;
    assign f_rdata = f_rdata_q;
    assign f_code  = f_code_q;
    assign d_ack   = d_ack_q;
    assign d_rdata = d_rdata_q;
    assign d_code  = d_code_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (default build, no watchdog).
module tb_mem_port_arbiter;
    localparam int         STARVE = 4;
    localparam logic [1:0] W_F    = 2'b01;
    localparam logic [1:0] W_D    = 2'b10;

    logic        clock = 1'b0;
    logic        reset_in;
    logic        f_req, d_req, d_we, f_ack, d_ack, m_req, m_we, m_ack;
    logic [35:0] f_addr, d_addr, m_addr;
    logic [63:0] d_wdata, f_rdata, d_rdata, m_wdata, m_rdata;
    logic [7:0]  d_be, m_be;
    logic [15:0] f_code, d_code, m_code;
    logic [1:0]  owner;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clock(clock), .reset_in(reset_in),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_code(f_code),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_code(d_code),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_code(m_code), .owner(owner)
    );

    always #5 clock = ~clock;

    typedef struct { logic [63:0] rdata; logic [15:0] code; int c; }     resp_t;
    typedef struct { logic [63:0] rdata; logic [15:0] code; int delay; } dir_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state.
    logic [1:0]  own_q[$];
    resp_t       resp_q[$];
    dir_t        dir_q[$];
    logic [1:0]  grant_log[$];
    logic        busy = 1'b0;
    int          idle_from = 0;
    int          loss = 0;
    logic        pause = 1'b0;
    logic        mem_en = 1'b1;
    logic [63:0] last_f_rdata = '0, last_d_rdata = '0;
    logic [15:0] last_f_code = '0, last_d_code = '0;

    // Requests as seen by the DUT at each rising edge.
    logic        samp_f, samp_d, samp_d_we;
    logic [35:0] samp_f_addr, samp_d_addr;
    logic [63:0] samp_d_wdata;
    logic [7:0]  samp_d_be;

    always @(posedge clock) begin
        cyc++;
        samp_f       = f_req;
        samp_d       = d_req;
        samp_f_addr  = f_addr;
        samp_d_we    = d_we;
        samp_d_addr  = d_addr;
        samp_d_wdata = d_wdata;
        samp_d_be    = d_be;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [35:0] raddr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    function automatic logic [63:0] rdata64();
        return {$urandom, $urandom};
    endfunction

    task automatic req_f(input logic [35:0] a);
        int n;
        n = 0;
        f_addr = a;
        f_req  = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!f_ack && n < 300);
        if (!f_ack) begin
            total++; bad++;
            $display("FAIL f_ack_timeout: got no f_ack expected f_ack within 300 cycles");
        end
        f_req = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [35:0] a, input logic [63:0] wd, input logic [7:0] be);
        int n;
        n = 0;
        d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        d_req = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!d_ack && n < 300);
        if (!d_ack) begin
            total++; bad++;
            $display("FAIL d_ack_timeout: got no d_ack expected d_ack within 300 cycles");
        end
        d_req = 1'b0;
    endtask

    task automatic rand_f(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(4, 0)) @(negedge clock);
            req_f(raddr());
        end
    endtask

    task automatic rand_d(input int n);
        logic [63:0] b;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(4, 0)) @(negedge clock);
            b = rdata64();
            req_d(b[8], raddr(), rdata64(), b[7:0]);
        end
    endtask

    // Grant monitor: timing of each grant, winner choice and m_* contents.
    initial begin : grant_mon
        logic        prev, rise, exp_g, g_we;
        logic [1:0]  w;
        logic [35:0] g_addr;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (pause) begin
                prev = m_req;
                continue;
            end
            rise  = m_req && !prev;
            prev  = m_req;
            exp_g = !busy && (cyc >= idle_from) && (samp_f || samp_d);
            if (rise || exp_g) chk("grant_timing", 64'(rise), 64'(exp_g));
            if (rise && exp_g) begin
                if (samp_f && samp_d) w = (loss == STARVE) ? W_F : W_D;
                else                  w = samp_f ? W_F : W_D;
                if (w == W_F)                       loss = 0;
                else if (samp_f && loss < STARVE)   loss = loss + 1;
                grant_log.push_back(owner);
                chk("grant_owner", 64'(owner), 64'(w));
                if (w == W_F) begin
                    g_we = 1'b0; g_addr = samp_f_addr;
                end else begin
                    g_we = samp_d_we; g_addr = samp_d_addr;
                    chk("grant_wdata", m_wdata, samp_d_wdata);
                    chk("grant_be", 64'(m_be), 64'(samp_d_be));
                end
                chk("grant_we", 64'(m_we), 64'(g_we));
                chk("grant_addr", 64'(m_addr), 64'(g_addr));
                own_q.push_back(w);
                busy = 1'b1;
            end else if (busy && m_req) begin
                chk("hold_addr", 64'(m_addr), 64'(g_addr));
                chk("hold_we", 64'(m_we), 64'(g_we));
            end
        end
    end

    // Memory responder: random latency, random data, stray acks while idle.
    initial begin : mem_model
        logic        armed, acked;
        int          dly;
        dir_t        dr;
        logic [63:0] rd;
        logic [15:0] cd;
        armed = 1'b0; acked = 1'b0; dly = 0; rd = '0; cd = '0;
        m_ack = 1'b0; m_rdata = '0; m_code = '0;
        forever begin
            @(negedge clock);
            m_ack = 1'b0;
            if (!mem_en || !m_req) begin
                armed = 1'b0;
                acked = 1'b0;
                if (mem_en && $urandom_range(3, 0) == 0) begin
                    m_ack = 1'b1; m_rdata = rdata64(); m_code = 16'($urandom);
                end
            end else if (!acked) begin
                if (!armed) begin
                    armed = 1'b1;
                    if (dir_q.size() > 0) begin
                        dr = dir_q.pop_front();
                        rd = dr.rdata; cd = dr.code; dly = dr.delay;
                    end else begin
                        rd  = rdata64();
                        cd  = ($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'h0000;
                        dly = $urandom_range(3, 0);
                    end
                end
                if (dly == 0) begin
                    m_ack = 1'b1; m_rdata = rd; m_code = cd;
                    resp_q.push_back('{rd, cd, cyc});
                    acked = 1'b1;
                end else begin
                    dly--;
                end
            end
        end
    end

    // Ack monitor: pops the expected winner and memory response.
    initial begin : ack_mon
        resp_t      r;
        logic [1:0] w;
        forever begin
            @(negedge clock);
            if (pause) continue;
            if (f_ack || d_ack) begin
                if (own_q.size() == 0 || resp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got f_ack=%0b d_ack=%0b expected no ack (cycle %0d)", f_ack, d_ack, cyc);
                end else begin
                    w = own_q.pop_front();
                    r = resp_q.pop_front();
                    chk("ack_who", 64'({d_ack, f_ack}), 64'(w));
                    chk("ack_latency", 64'(cyc), 64'(r.c + 1));
                    if (w == W_F) begin
                        last_f_rdata = r.rdata; last_f_code = r.code;
                    end else begin
                        last_d_rdata = r.rdata; last_d_code = r.code;
                    end
                    busy = 1'b0;
                    idle_from = cyc + 2;
                end
                chk("f_rdata", f_rdata, last_f_rdata);
                chk("f_code", 64'(f_code), 64'(last_f_code));
                chk("d_rdata", d_rdata, last_d_rdata);
                chk("d_code", 64'(d_code), 64'(last_d_code));
            end
        end
    end

    initial begin : guard
        #300000;
        $display("FAIL global_timeout: got no finish expected finish by 300000");
        $fatal(1);
    end

    initial begin : main
        int n;
        reset_in = 1'b1;
        f_req = 0; f_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (3) @(negedge clock);
        chk("rst_m_req", 64'(m_req), 0);
        chk("rst_owner", 64'(owner), 0);
        chk("rst_acks", 64'({f_ack, d_ack}), 0);
        chk("rst_m_addr", 64'(m_addr), 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_d_code", 64'(d_code), 0);
        reset_in = 1'b0;
        @(negedge clock);

        // Fetch alone, fixed response.
        dir_q.push_back('{64'hDEAD_BEEF, 16'h0000, 2});
        req_f(36'h100);
        chk("t1_f_rdata", f_rdata, 64'hDEAD_BEEF);
        repeat (2) @(negedge clock);

        // Simultaneous requests: D store wins first.
        grant_log.delete();
        fork
            req_f(raddr());
            req_d(1'b1, 36'h200, rdata64(), 8'h0F);
        join
        if (grant_log.size() >= 2) begin
            chk("t2_first", 64'(grant_log[0]), 64'(W_D));
            chk("t2_second", 64'(grant_log[1]), 64'(W_F));
        end else begin
            total++; bad++;
            $display("FAIL t2_grants: got %0d grants expected 2", grant_log.size());
        end
        repeat (2) @(negedge clock);

        // D back-to-back with F pending: F must win the 5th grant.
        grant_log.delete();
        fork
            for (int i = 0; i < 6; i++) req_d(1'b0, raddr(), rdata64(), 8'hFF);
            req_f(raddr());
        join
        if (grant_log.size() >= 5) begin
            chk("t3_4th", 64'(grant_log[3]), 64'(W_D));
            chk("t3_5th", 64'(grant_log[4]), 64'(W_F));
        end else begin
            total++; bad++;
            $display("FAIL t3_grants: got %0d grants expected >=5", grant_log.size());
        end
        repeat (2) @(negedge clock);

        // Exception code on a D load; F outputs must not move.
        dir_q.push_back('{64'h1234_5678_9ABC_DEF0, 16'h0007, 1});
        req_d(1'b0, raddr(), '0, 8'hFF);
        chk("t4_d_code", 64'(d_code), 64'h0007);

        // Random mixed traffic.
        fork
            rand_f(40);
            rand_d(40);
        join
        repeat (4) @(negedge clock);

        // Reset in the middle of a D transaction.
        mem_en = 1'b0;
        d_we = 1'b0; d_addr = raddr(); d_wdata = '0; d_be = 8'hFF;
        d_req = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(m_req && owner == W_D) && n < 20);
        chk("t5_busy_d", 64'(owner), 64'(W_D));
        @(posedge clock);
        #1 pause = 1'b1;
        @(negedge clock);
        reset_in = 1'b1;
        d_req = 1'b0;
        @(negedge clock);
        chk("t5_m_req", 64'(m_req), 0);
        chk("t5_owner", 64'(owner), 0);
        chk("t5_acks", 64'({f_ack, d_ack}), 0);
        chk("t5_d_rdata", d_rdata, 0);
        reset_in = 1'b0;
        own_q.delete(); resp_q.delete();
        busy = 1'b0; idle_from = 0; loss = 0;
        last_f_rdata = '0; last_f_code = '0; last_d_rdata = '0; last_d_code = '0;
        mem_en = 1'b1;
        @(posedge clock);
        #1 pause = 1'b0;
        dir_q.push_back('{64'h0BAD_F00D, 16'h0000, 0});
        req_f(36'h300);
        chk("t5_f_rdata", f_rdata, 64'h0BAD_F00D);

        repeat (5) @(negedge clock);
        chk("end_own_q", 64'(own_q.size()), 0);
        chk("end_resp_q", 64'(resp_q.size()), 0);
        chk("end_f_hold", f_rdata, last_f_rdata);
        chk("end_d_hold", d_rdata, last_d_rdata);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
